// File: rtl/wiphy_dac_fifo.sv
// Transmit buffer between the sample stream and the DAC: AXI4-Stream in, one beat per DAC strobe out,
// with prefill threshold, tlast burst framing, underflow zero-fill and a sticky underflow interrupt.
module wiphy_dac_fifo #(
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 64,
  parameter int THRESHOLD    = 16,
  localparam int BEAT        = 2 * SAMPLE_WIDTH * CHANNELS,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             enable,
  input  logic                             s_axis_tvalid,
  input  logic [BEAT-1:0]                  s_axis_tdata,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,
  input  logic                             dac_strobe,
  output logic [CHANNELS-1:0]              dac_valid,
  output logic [CHANNELS*SAMPLE_WIDTH-1:0] dac_data_i,
  output logic [CHANNELS*SAMPLE_WIDTH-1:0] dac_data_q,
  output logic [CW-1:0]                    level,
  output logic [15:0]                      underflow_count,
  output logic                             irq,
  input  logic                             irq_clear
);

  localparam int SW = SAMPLE_WIDTH;

  typedef enum logic [1:0] {IDLE, PREFILL, RUN} state_t;

  state_t        state;
  logic [BEAT:0] mem [DEPTH];
  logic [CW-1:0] wptr, rptr, tl_cnt;
  logic [CW-1:0] wptr_nxt, rptr_nxt, level_nxt, tl_cnt_nxt;
  logic          push, pop, under, strobe_run;
  logic [BEAT:0] rd_entry;
  logic [CHANNELS*SW-1:0] rd_i, rd_q;

  always_comb begin
    push       = s_axis_tvalid && s_axis_tready;
    strobe_run = enable && (state == RUN) && dac_strobe;
    pop        = strobe_run && (level != '0);
    under      = strobe_run && (level == '0);
    rd_entry   = mem[rptr[CW-2:0]];
    wptr_nxt   = wptr + CW'(push);
    // Flush targets the post-push write pointer so a beat accepted while enable falls is discarded too.
    rptr_nxt   = enable ? rptr + CW'(pop) : wptr_nxt;
    level_nxt  = wptr_nxt - rptr_nxt;
    tl_cnt_nxt = enable ? tl_cnt + CW'(push && s_axis_tlast) - CW'(pop && rd_entry[BEAT]) : '0;
  end

  always_comb begin
    rd_i = '0;
    rd_q = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      rd_i[c*SW +: SW] = rd_entry[c*2*SW +: SW];
      rd_q[c*SW +: SW] = rd_entry[c*2*SW + SW +: SW];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[CW-2:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      wptr            <= '0;
      rptr            <= '0;
      tl_cnt          <= '0;
      level           <= '0;
      s_axis_tready   <= 1'b0;
      dac_valid       <= '0;
      dac_data_i      <= '0;
      dac_data_q      <= '0;
      underflow_count <= '0;
      irq             <= 1'b0;
    end else begin
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      tl_cnt        <= tl_cnt_nxt;
      level         <= level_nxt;
      s_axis_tready <= enable && (level_nxt != CW'(DEPTH));
      dac_valid     <= {CHANNELS{strobe_run}};

      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= PREFILL;
          PREFILL: if (level >= CW'(THRESHOLD) || tl_cnt != '0) state <= RUN;
          RUN:     if (pop && rd_entry[BEAT]) state <= PREFILL;
          default: state <= IDLE;
        endcase
      end

      if (pop) begin
        dac_data_i <= rd_i;
        dac_data_q <= rd_q;
      end else if (under) begin
        dac_data_i <= '0;
        dac_data_q <= '0;
      end

      if (under && underflow_count != '1) underflow_count <= underflow_count + 16'd1;

      if (under)          irq <= 1'b1;
      else if (irq_clear) irq <= 1'b0;
    end
  end

endmodule
